accelerator_transformer_stream_responder: RTL and testbench

//   Controller-side stream endpoint for the standard transformer accelerator. Answers the controller's
//   X_IN_ENABLE element requests from a host-loaded vector buffer and captures the H_OUT result stream
//   on H_OUT_ENABLE into a host-readable buffer. Sits where the transformer stimulus sits in bench

---
 rtl/accelerator_transformer_stream_responder.sv | 129 ++++++++++++
 tb/tb_accelerator_transformer_stream_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_transformer_stream_responder.sv
// Stream endpoint for the transformer controller: serves X_IN elements
// from a host-loaded buffer and captures the H_OUT stream for host readback.
module accelerator_transformer_stream_responder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int ADDRESS_SIZE = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    OVERFLOW,
  input  logic [DATA_SIZE-1:0]    SIZE_X_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_H_IN,
  input  logic                    LOAD_ENABLE,
  input  logic [ADDRESS_SIZE-1:0] LOAD_ADDRESS,
  input  logic [DATA_SIZE-1:0]    LOAD_DATA,
  input  logic [ADDRESS_SIZE-1:0] READ_ADDRESS,
  output logic [DATA_SIZE-1:0]    READ_DATA,
  input  logic                    X_IN_ENABLE,
  output logic [DATA_SIZE-1:0]    X_IN,
  input  logic                    H_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0]    H_OUT
);

  localparam int AW    = ADDRESS_SIZE;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [DATA_SIZE-1:0] DEPTH_D = DATA_SIZE'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW:0] size_x_q, size_x_d;
  logic [AW:0] size_h_q, size_h_d;
  logic [AW:0] x_idx_q, x_idx_d;
  logic [AW:0] h_idx_q, h_idx_d;
  logic        ovf_q, ovf_d;
  logic [DATA_SIZE-1:0] x_in_q, x_in_d;
  logic [DATA_SIZE-1:0] rdata_q;
  logic        h_wr;

  logic [DATA_SIZE-1:0] xbuf_q [DEPTH];
  logic [DATA_SIZE-1:0] hbuf_q [DEPTH];

  function automatic logic [AW:0] clamp(input logic [DATA_SIZE-1:0] s);
    return (s > DEPTH_D) ? DEPTH_W : s[AW:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    size_x_d = size_x_q;
    size_h_d = size_h_q;
    x_idx_d  = x_idx_q;
    h_idx_d  = h_idx_q;
    ovf_d    = ovf_q;
    x_in_d   = x_in_q;
    h_wr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d  = S_STREAM;
          size_x_d = clamp(SIZE_X_IN);
          size_h_d = clamp(SIZE_H_IN);
          x_idx_d  = '0;
          h_idx_d  = '0;
          ovf_d    = 1'b0;
          x_in_d   = xbuf_q[0];
        end
      end
      S_STREAM: begin
        if (X_IN_ENABLE) begin
          if (x_idx_q < size_x_q) x_idx_d = x_idx_q + 1'b1;
          else                    ovf_d   = 1'b1;
        end
        if (H_OUT_ENABLE) begin
          if (h_idx_q < size_h_q) begin
            h_idx_d = h_idx_q + 1'b1;
            h_wr    = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        // Past the last element X_IN keeps showing the final one served.
        if (x_idx_d < size_x_q) x_in_d = xbuf_q[x_idx_d[AW-1:0]];
        if (x_idx_d == size_x_q && h_idx_d == size_h_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      size_x_q <= '0;
      size_h_q <= '0;
      x_idx_q  <= '0;
      h_idx_q  <= '0;
      ovf_q    <= 1'b0;
      x_in_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      size_x_q <= size_x_d;
      size_h_q <= size_h_d;
      x_idx_q  <= x_idx_d;
      h_idx_q  <= h_idx_d;
      ovf_q    <= ovf_d;
      x_in_q   <= x_in_d;
      rdata_q  <= hbuf_q[READ_ADDRESS];
    end
  end

  always_ff @(posedge CLK) begin
    if (LOAD_ENABLE) xbuf_q[LOAD_ADDRESS] <= LOAD_DATA;
    if (h_wr && !RST) hbuf_q[h_idx_q[AW-1:0]] <= H_OUT;
  end

  assign READY     = (state_q == S_DONE);
  assign OVERFLOW  = ovf_q;
  assign X_IN      = x_in_q;
  assign READ_DATA = rdata_q;

endmodule

// File: tb/tb_accelerator_transformer_stream_responder.sv
// Randomised bench for the stream responder against a transaction-level
// model of the run (counts, sizes, buffers) plus directed scenarios.
module tb_accelerator_transformer_stream_responder;

  localparam int DW    = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst, start, load, xen, hen;
  logic [DW-1:0] size_x, size_h, ldata, hout;
  logic [AW-1:0] laddr, raddr;
  logic          ready, ovf;
  logic [DW-1:0] rdata, xin;

  always #5 clk = ~clk;

  accelerator_transformer_stream_responder #(
    .DATA_SIZE(DW), .CONTROL_SIZE(64), .ADDRESS_SIZE(AW)
  ) dut (
    .CLK(clk), .RST(rst), .START(start),
    .READY(ready), .OVERFLOW(ovf),
    .SIZE_X_IN(size_x), .SIZE_H_IN(size_h),
    .LOAD_ENABLE(load), .LOAD_ADDRESS(laddr), .LOAD_DATA(ldata),
    .READ_ADDRESS(raddr), .READ_DATA(rdata),
    .X_IN_ENABLE(xen), .X_IN(xin),
    .H_OUT_ENABLE(hen), .H_OUT(hout)
  );

  // reference model: run mode 0=idle 1=streaming 2=done
  logic [DW-1:0] mx [DEPTH];
  logic [DW-1:0] mh [DEPTH];
  bit            hv [DEPTH];
  int            m_mode, szx, szh, xc, hc;
  bit            m_ovf, rd_known;
  logic [DW-1:0] m_xin, m_rd;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int clampsz(input logic [DW-1:0] s);
    return (s > 64'd64) ? 64 : int'(s);
  endfunction

  task automatic model_step();
    logic [DW-1:0] rd_new;
    bit            rdk_new;
    if (rst) begin
      m_mode = 0; m_ovf = 0; m_xin = '0;
      m_rd = '0; rd_known = 1; xc = 0; hc = 0;
    end else begin
      rd_new  = mh[raddr];
      rdk_new = hv[raddr];
      if (m_mode != 1) begin
        if (start) begin
          szx = clampsz(size_x); szh = clampsz(size_h);
          xc = 0; hc = 0; m_ovf = 0;
          m_xin = mx[0]; m_mode = 1;
        end
      end else begin
        if (xen) begin
          if (xc < szx) xc++;
          else m_ovf = 1;
        end
        if (hen) begin
          if (hc < szh) begin
            mh[hc] = hout; hv[hc] = 1; hc++;
          end else m_ovf = 1;
        end
        if (xc < szx) m_xin = mx[xc];
        if (xc == szx && hc == szh) m_mode = 2;
      end
      m_rd = rd_new; rd_known = rdk_new;
    end
    if (load) mx[laddr] = ldata;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ready", {63'd0, ready}, {63'd0, m_mode == 2});
    check("overflow", {63'd0, ovf}, {63'd0, m_ovf});
    check("x_in", xin, m_xin);
    if (rd_known) check("read_data", rdata, m_rd);
  endtask

  task automatic clr();
    start = 0; load = 0; xen = 0; hen = 0; rst = 0;
  endtask

  task automatic run(input int sx, input int sh);
    size_x = DW'(sx); size_h = DW'(sh); start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    clr();
    rst = 1; size_x = 0; size_h = 0;
    laddr = 0; ldata = 0; raddr = 0; hout = 0;
    @(negedge clk);
    tick(); tick();
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_xin", xin, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rst = 0;

    for (int i = 0; i < DEPTH; i++) begin
      load = 1; laddr = AW'(i);
      ldata = (i < 4) ? DW'(i + 1) : {$urandom, $urandom};
      tick();
    end
    load = 0;

    // four x requests
    run(4, 0);
    check("t1_first", xin, 64'd1);
    for (int k = 0; k < 4; k++) begin
      xen = 1; tick();
      check("t1_seq", xin, DW'((k + 2 > 4) ? 4 : k + 2));
    end
    xen = 0;
    check("t1_ready", {63'd0, ready}, 64'd1);

    // three h captures and readback
    run(0, 3);
    for (int k = 0; k < 3; k++) begin
      hen = 1; hout = DW'((k + 1) * 10); tick();
    end
    hen = 0;
    check("t2_ready", {63'd0, ready}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      raddr = AW'(k); tick();
      check("t2_read", rdata, DW'((k + 1) * 10));
    end

    // simultaneous enables
    run(2, 2);
    for (int k = 0; k < 2; k++) begin
      xen = 1; hen = 1; hout = {$urandom, $urandom}; tick();
    end
    xen = 0; hen = 0;
    check("t3_ready", {63'd0, ready}, 64'd1);
    check("t3_ovf", {63'd0, ovf}, 64'd0);

    // x overflow, X_IN holds, next START clears
    run(1, 1);
    xen = 1; tick(); tick(); xen = 0;
    check("t4_ovf", {63'd0, ovf}, 64'd1);
    check("t4_xin", xin, 64'd1);
    hen = 1; hout = 64'h55; tick(); hen = 0;
    run(1, 0);
    check("t4_clr", {63'd0, ovf}, 64'd0);
    xen = 1; tick(); xen = 0;

    // reset mid-stream
    run(4, 4);
    xen = 1; tick(); tick(); xen = 0;
    rst = 1; tick(); rst = 0;
    check("t5_ready", {63'd0, ready}, 64'd0);
    check("t5_xin", xin, 64'd0);
    xen = 1; hen = 1; tick(); tick(); xen = 0; hen = 0;
    check("t5_ign", {63'd0, ovf}, 64'd0);

    // size clamp to buffer depth
    run(100, 1);
    xen = 1;
    for (int k = 0; k < 64; k++) tick();
    xen = 0;
    check("t6_ovf0", {63'd0, ovf}, 64'd0);
    xen = 1; tick(); xen = 0;
    check("t6_ovf1", {63'd0, ovf}, 64'd1);
    hen = 1; tick(); hen = 0;
    check("t6_ready", {63'd0, ready}, 64'd1);

    // randomised runs
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 4; k++) begin
        load = 1'($urandom_range(0, 1));
        laddr = AW'($urandom); ldata = {$urandom, $urandom};
        raddr = AW'($urandom);
        tick();
      end
      load = 0;
      if ($urandom_range(0, 7) == 0)
        run($urandom_range(60, 80), $urandom_range(0, 70));
      else
        run($urandom_range(0, 12), $urandom_range(0, 12));
      for (int c = 0; c < 300 && m_mode == 1; c++) begin
        xen   = ($urandom_range(0, 9) < 6);
        hen   = ($urandom_range(0, 9) < 6);
        hout  = {$urandom, $urandom};
        start = ($urandom_range(0, 19) == 0);
        rst   = ($urandom_range(0, 199) == 0);
        raddr = AW'($urandom);
        tick();
      end
      clr();
      xen = 1; hen = 1; tick(); clr();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
